// File: rtl/riscv_pipe_core.sv
// riscv_pipe_core: 5-stage in-order RV32I-subset pipeline with no interlocks; software schedules every hazard
module riscv_pipe_core (
    input  logic        clk,
    input  logic        rset,
    input  logic [31:0] ins,
    input  logic [31:0] MEM_rData,
    output logic [31:0] pc,
    output logic [7:0]  MEM_addr,
    output logic [31:0] MEM_wDATA,
    output logic        dm_we
);
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [31:0] r_pc;
    logic [31:0] r_ifid_ins, r_ifid_pc;
    logic [31:0] r_idex_pc, r_idex_a, r_idex_b, r_idex_imm;
    logic [4:0]  r_idex_rd;
    alu_op_e     r_idex_op;
    logic        r_idex_use_imm, r_idex_we, r_idex_mr, r_idex_mw, r_idex_br, r_idex_jal;
    logic [31:0] r_exmem_res, r_exmem_b;
    logic [4:0]  r_exmem_rd;
    logic        r_exmem_we, r_exmem_mr, r_exmem_mw;
    logic [31:0] r_memwb_val;
    logic [4:0]  r_memwb_rd;
    logic        r_memwb_we;
    logic [31:0] r_rf [0:31];

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j;
    logic [31:0] w_imm, w_rs1_val, w_rs2_val;
    alu_op_e     w_op, w_f3_op;
    logic        w_f3_ok, w_use_imm, w_we, w_mr, w_mw, w_br, w_jal;
    logic [31:0] w_alu_b, w_alu, w_ex_res, w_target;
    logic        w_redirect;

    assign w_opc   = r_ifid_ins[6:0];
    assign w_rd    = r_ifid_ins[11:7];
    assign w_f3    = r_ifid_ins[14:12];
    assign w_rs1   = r_ifid_ins[19:15];
    assign w_rs2   = r_ifid_ins[24:20];
    assign w_imm_i = {{20{r_ifid_ins[31]}}, r_ifid_ins[31:20]};
    assign w_imm_s = {{20{r_ifid_ins[31]}}, r_ifid_ins[31:25], r_ifid_ins[11:7]};
    assign w_imm_b = {{19{r_ifid_ins[31]}}, r_ifid_ins[31], r_ifid_ins[7], r_ifid_ins[30:25],
                      r_ifid_ins[11:8], 1'b0};
    assign w_imm_j = {{11{r_ifid_ins[31]}}, r_ifid_ins[31], r_ifid_ins[19:12], r_ifid_ins[20],
                      r_ifid_ins[30:21], 1'b0};

    // Write-through register read: a same-cycle WB to the source register is returned directly
    assign w_rs1_val = (w_rs1 == 5'd0) ? '0 :
                       (r_memwb_we && r_memwb_rd == w_rs1) ? r_memwb_val : r_rf[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? '0 :
                       (r_memwb_we && r_memwb_rd == w_rs2) ? r_memwb_val : r_rf[w_rs2];

    // funct3 to ALU operation shared by R-type and I-type; unsupported funct3 becomes a NOP
    always_comb begin
        w_f3_ok = 1'b1;
        w_f3_op = ALU_ADD;
        case (w_f3)
            3'b000:  w_f3_op = ALU_ADD;
            3'b111:  w_f3_op = ALU_AND;
            3'b110:  w_f3_op = ALU_OR;
            3'b010:  w_f3_op = ALU_SLT;
            default: w_f3_ok = 1'b0;
        endcase
    end

    // Main decoder producing the control word and immediate; unknown opcodes leave all controls low
    always_comb begin
        w_op      = ALU_ADD;
        w_use_imm = 1'b0;
        w_we      = 1'b0;
        w_mr      = 1'b0;
        w_mw      = 1'b0;
        w_br      = 1'b0;
        w_jal     = 1'b0;
        w_imm     = w_imm_i;
        case (w_opc)
            OP_R: begin
                w_we = w_f3_ok;
                w_op = (w_f3 == 3'b000 && r_ifid_ins[30]) ? ALU_SUB : w_f3_op;
            end
            OP_I: begin
                w_we      = w_f3_ok;
                w_op      = w_f3_op;
                w_use_imm = 1'b1;
            end
            OP_LW: begin
                w_we      = 1'b1;
                w_mr      = 1'b1;
                w_use_imm = 1'b1;
            end
            OP_SW: begin
                w_mw      = 1'b1;
                w_use_imm = 1'b1;
                w_imm     = w_imm_s;
            end
            OP_BEQ: begin
                w_br  = 1'b1;
                w_op  = ALU_SUB;
                w_imm = w_imm_b;
            end
            OP_JAL: begin
                w_jal = 1'b1;
                w_we  = 1'b1;
                w_imm = w_imm_j;
            end
            default: w_we = 1'b0;
        endcase
    end

    assign w_alu_b = r_idex_use_imm ? r_idex_imm : r_idex_b;

    // EX-stage ALU; beq uses the subtract result as its zero flag
    always_comb begin
        w_alu = r_idex_a + w_alu_b;
        case (r_idex_op)
            ALU_SUB: w_alu = r_idex_a - w_alu_b;
            ALU_AND: w_alu = r_idex_a & w_alu_b;
            ALU_OR:  w_alu = r_idex_a | w_alu_b;
            ALU_SLT: w_alu = {31'd0, $signed(r_idex_a) < $signed(w_alu_b)};
            default: w_alu = r_idex_a + w_alu_b;
        endcase
    end

    assign w_ex_res   = r_idex_jal ? r_idex_pc + 32'd4 : w_alu;
    assign w_target   = r_idex_pc + r_idex_imm;
    assign w_redirect = r_idex_jal || (r_idex_br && w_alu == 32'd0);

    assign pc        = r_pc;
    assign MEM_addr  = r_exmem_res[9:2];
    assign MEM_wDATA = r_exmem_b;
    assign dm_we     = r_exmem_mw;

    // Fetch PC: sequential unless the instruction in EX redirects; younger instructions are kept
    always_ff @(posedge clk) begin
        if (rset) r_pc <= '0;
        else      r_pc <= w_redirect ? w_target : r_pc + 32'd4;
    end

    // IF/ID register
    always_ff @(posedge clk) begin
        if (rset) begin
            r_ifid_ins <= '0;
            r_ifid_pc  <= '0;
        end else begin
            r_ifid_ins <= ins;
            r_ifid_pc  <= r_pc;
        end
    end

    // ID/EX register carrying operands, immediate and control word
    always_ff @(posedge clk) begin
        if (rset) begin
            r_idex_pc      <= '0;
            r_idex_a       <= '0;
            r_idex_b       <= '0;
            r_idex_imm     <= '0;
            r_idex_rd      <= '0;
            r_idex_op      <= ALU_ADD;
            r_idex_use_imm <= 1'b0;
            r_idex_we      <= 1'b0;
            r_idex_mr      <= 1'b0;
            r_idex_mw      <= 1'b0;
            r_idex_br      <= 1'b0;
            r_idex_jal     <= 1'b0;
        end else begin
            r_idex_pc      <= r_ifid_pc;
            r_idex_a       <= w_rs1_val;
            r_idex_b       <= w_rs2_val;
            r_idex_imm     <= w_imm;
            r_idex_rd      <= w_rd;
            r_idex_op      <= w_op;
            r_idex_use_imm <= w_use_imm;
            r_idex_we      <= w_we;
            r_idex_mr      <= w_mr;
            r_idex_mw      <= w_mw;
            r_idex_br      <= w_br;
            r_idex_jal     <= w_jal;
        end
    end

    // EX/MEM register
    always_ff @(posedge clk) begin
        if (rset) begin
            r_exmem_res <= '0;
            r_exmem_b   <= '0;
            r_exmem_rd  <= '0;
            r_exmem_we  <= 1'b0;
            r_exmem_mr  <= 1'b0;
            r_exmem_mw  <= 1'b0;
        end else begin
            r_exmem_res <= w_ex_res;
            r_exmem_b   <= r_idex_b;
            r_exmem_rd  <= r_idex_rd;
            r_exmem_we  <= r_idex_we;
            r_exmem_mr  <= r_idex_mr;
            r_exmem_mw  <= r_idex_mw;
        end
    end

    // MEM/WB register selecting load data or the EX result
    always_ff @(posedge clk) begin
        if (rset) begin
            r_memwb_val <= '0;
            r_memwb_rd  <= '0;
            r_memwb_we  <= 1'b0;
        end else begin
            r_memwb_val <= r_exmem_mr ? MEM_rData : r_exmem_res;
            r_memwb_rd  <= r_exmem_rd;
            r_memwb_we  <= r_exmem_we;
        end
    end

    // Register file write-back; x0 is never written
    always_ff @(posedge clk) begin
        if (rset) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else if (r_memwb_we && r_memwb_rd != 5'd0) begin
            r_rf[r_memwb_rd] <= r_memwb_val;
        end
    end
endmodule

// File: tb/tb_riscv_pipe_core.sv
// tb_riscv_pipe_core: directed programs with hand-computed results, observed through stores and pc
module tb_riscv_pipe_core;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rset = 1'b1;
    logic [31:0] ins, MEM_rData, pc, MEM_wDATA;
    logic [7:0]  MEM_addr;
    logic        dm_we;
    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:255];
    int          n_tests = 0;
    int          n_fail = 0;

    riscv_pipe_core dut (
        .clk       (clk),
        .rset      (rset),
        .ins       (ins),
        .MEM_rData (MEM_rData),
        .pc        (pc),
        .MEM_addr  (MEM_addr),
        .MEM_wDATA (MEM_wDATA),
        .dm_we     (dm_we)
    );

    always #5 clk = ~clk;

    assign ins       = imem[pc[9:2]];
    assign MEM_rData = dmem[MEM_addr];

    always @(posedge clk) if (dm_we) dmem[MEM_addr] <= MEM_wDATA;

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [31:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [31:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] jal(input logic [4:0] rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic load_nops();
        for (int i = 0; i < 256; i++) begin
            imem[i] = NOP;
            dmem[i] <= 32'hFFFF_FFFF;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rset = 1'b0;
    endtask

    task automatic test_reset();
        load_nops();
        @(negedge clk);
        rset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (pc !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_pc: got %h expected 00000000", pc);
        end
        n_tests++;
        if (dm_we !== 1'b0 || MEM_addr !== 8'd0 || MEM_wDATA !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mem: got we=%b addr=%h wdata=%h expected 0/00/00000000",
                     dm_we, MEM_addr, MEM_wDATA);
        end
        rset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (pc !== 32'(4 * k)) begin
                n_fail++;
                $display("FAIL reset_seq%0d: got %h expected %h", k, pc, 32'(4 * k));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alu();
        logic [31:0] exp_v [0:15];
        load_nops();
        imem[0]  = addi(1, 0, 5);
        imem[1]  = addi(2, 0, -3);
        imem[5]  = enc_r(7'b0000000, 2, 1, 3'b000, 3);
        imem[6]  = enc_r(7'b0100000, 2, 1, 3'b000, 4);
        imem[7]  = enc_r(7'b0000000, 1, 2, 3'b010, 5);
        imem[8]  = enc_r(7'b0000000, 2, 1, 3'b111, 6);
        imem[9]  = enc_r(7'b0000000, 2, 1, 3'b110, 7);
        imem[10] = enc_i(15, 2, 3'b111, 8, 7'b0010011);
        imem[11] = enc_i(32'h30, 1, 3'b110, 9, 7'b0010011);
        imem[12] = enc_i(-2, 2, 3'b010, 10, 7'b0010011);
        imem[13] = enc_r(7'b0000000, 2, 1, 3'b010, 11);
        for (int r = 3; r <= 11; r++) imem[14 + r] = sw(5'(r), 0, 32'(4 * r));
        exp_v[3] = 32'd2;          exp_v[4] = 32'd8;          exp_v[5] = 32'd1;
        exp_v[6] = 32'd5;          exp_v[7] = 32'hFFFF_FFFD;  exp_v[8] = 32'hD;
        exp_v[9] = 32'h35;         exp_v[10] = 32'd1;         exp_v[11] = 32'd0;
        do_reset();
        repeat (40) @(negedge clk);
        for (int r = 3; r <= 11; r++) begin
            n_tests++;
            if (dmem[r] !== exp_v[r]) begin
                n_fail++;
                $display("FAIL alu_x%0d: got %h expected %h", r, dmem[r], exp_v[r]);
            end
        end
    endtask

    task automatic test_stale_read();
        load_nops();
        imem[0]  = addi(1, 0, 7);
        imem[1]  = addi(2, 1, 1);
        imem[2]  = addi(4, 0, 7);
        imem[5]  = addi(5, 4, 1);
        imem[6]  = addi(6, 0, 7);
        imem[8]  = addi(7, 6, 1);
        imem[12] = sw(2, 0, 8);
        imem[13] = sw(5, 0, 20);
        imem[14] = sw(7, 0, 28);
        do_reset();
        repeat (30) @(negedge clk);
        n_tests++;
        if (dmem[2] !== 32'd1) begin
            n_fail++;
            $display("FAIL stale_dist1: got %h expected 00000001", dmem[2]);
        end
        n_tests++;
        if (dmem[5] !== 32'd8) begin
            n_fail++;
            $display("FAIL writethrough_dist3: got %h expected 00000008", dmem[5]);
        end
        n_tests++;
        if (dmem[7] !== 32'd1) begin
            n_fail++;
            $display("FAIL stale_dist2: got %h expected 00000001", dmem[7]);
        end
    endtask

    task automatic test_load_store();
        int we_cnt = 0;
        load_nops();
        dmem[8'h20] <= 32'hDEAD_BEEF;
        imem[0]  = addi(1, 0, 32'h40);
        imem[1]  = enc_i(32'h80, 0, 3'b010, 2, 7'b0000011);
        imem[5]  = sw(2, 1, 4);
        imem[8]  = enc_i(4, 1, 3'b010, 3, 7'b0000011);
        imem[12] = sw(3, 0, 12);
        do_reset();
        for (int c = 0; c < 30; c++) begin
            if (dm_we === 1'b1) we_cnt++;
            if (c == 8) begin
                n_tests++;
                if (dm_we !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sw_we: got %b expected 1", dm_we);
                end
                n_tests++;
                if (MEM_addr !== 8'h11) begin
                    n_fail++;
                    $display("FAIL sw_addr: got %h expected 11", MEM_addr);
                end
                n_tests++;
                if (MEM_wDATA !== 32'hDEAD_BEEF) begin
                    n_fail++;
                    $display("FAIL sw_wdata: got %h expected deadbeef", MEM_wDATA);
                end
            end
            @(negedge clk);
        end
        n_tests++;
        if (we_cnt != 2) begin
            n_fail++;
            $display("FAIL store_count: got %0d expected 2", we_cnt);
        end
        n_tests++;
        if (dmem[8'h11] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL sw_mem: got %h expected deadbeef", dmem[8'h11]);
        end
        n_tests++;
        if (dmem[3] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL lw_x3: got %h expected deadbeef", dmem[3]);
        end
    endtask

    task automatic test_branch();
        load_nops();
        imem[0]  = beq(0, 0, 16);
        imem[1]  = addi(6, 0, 1);
        imem[2]  = addi(7, 0, 1);
        imem[3]  = addi(8, 0, 1);
        imem[4]  = addi(9, 0, 1);
        imem[8]  = sw(6, 0, 24);
        imem[9]  = sw(7, 0, 28);
        imem[10] = sw(8, 0, 32);
        imem[11] = sw(9, 0, 36);
        do_reset();
        for (int c = 0; c < 25; c++) begin
            if (c == 3 || c == 4) begin
                n_tests++;
                if (pc !== 32'(4 * c + 4)) begin
                    n_fail++;
                    $display("FAIL beq_taken_pc_c%0d: got %h expected %h", c, pc, 32'(4 * c + 4));
                end
            end
            @(negedge clk);
        end
        n_tests++;
        if (dmem[6] !== 32'd1 || dmem[7] !== 32'd1) begin
            n_fail++;
            $display("FAIL delay_slots: got x6=%h x7=%h expected 00000001/00000001", dmem[6], dmem[7]);
        end
        n_tests++;
        if (dmem[8] !== 32'd0) begin
            n_fail++;
            $display("FAIL skipped_x8: got %h expected 00000000", dmem[8]);
        end
        n_tests++;
        if (dmem[9] !== 32'd1) begin
            n_fail++;
            $display("FAIL target_x9: got %h expected 00000001", dmem[9]);
        end
        load_nops();
        imem[0] = addi(1, 0, 1);
        imem[3] = beq(1, 2, 16);
        imem[4] = addi(8, 0, 3);
        imem[8] = sw(8, 0, 32);
        do_reset();
        for (int c = 0; c < 20; c++) begin
            if (c == 6) begin
                n_tests++;
                if (pc !== 32'd24) begin
                    n_fail++;
                    $display("FAIL beq_not_taken_pc: got %h expected 00000018", pc);
                end
            end
            @(negedge clk);
        end
        n_tests++;
        if (dmem[8] !== 32'd3) begin
            n_fail++;
            $display("FAIL not_taken_x8: got %h expected 00000003", dmem[8]);
        end
    endtask

    task automatic test_jal_x0();
        load_nops();
        imem[0]  = addi(0, 0, 9);
        imem[8]  = jal(1, 8);
        imem[14] = sw(1, 0, 4);
        imem[15] = sw(0, 0, 0);
        do_reset();
        for (int c = 0; c < 30; c++) begin
            if (c == 11 || c == 12) begin
                n_tests++;
                if (pc !== 32'(32'h28 + 4 * (c - 11))) begin
                    n_fail++;
                    $display("FAIL jal_pc_c%0d: got %h expected %h", c, pc, 32'(32'h28 + 4 * (c - 11)));
                end
            end
            @(negedge clk);
        end
        n_tests++;
        if (dmem[1] !== 32'h24) begin
            n_fail++;
            $display("FAIL jal_link: got %h expected 00000024", dmem[1]);
        end
        n_tests++;
        if (dmem[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL x0_zero: got %h expected 00000000", dmem[0]);
        end
    endtask

    task automatic test_reset_mid();
        load_nops();
        imem[0] = addi(5, 0, 11);
        imem[1] = addi(6, 0, 22);
        imem[2] = addi(7, 0, 33);
        imem[3] = sw(0, 0, 60);
        do_reset();
        repeat (5) @(negedge clk);
        rset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (pc !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset_pc: got %h expected 00000000", pc);
        end
        n_tests++;
        if (dm_we !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_we: got %b expected 0", dm_we);
        end
        for (int i = 0; i < 256; i++) imem[i] = NOP;
        imem[0] = sw(5, 0, 20);
        imem[1] = sw(6, 0, 24);
        imem[2] = sw(7, 0, 28);
        @(negedge clk);
        rset = 1'b0;
        repeat (15) @(negedge clk);
        for (int r = 5; r <= 7; r++) begin
            n_tests++;
            if (dmem[r] !== 32'd0) begin
                n_fail++;
                $display("FAIL mid_reset_x%0d: got %h expected 00000000", r, dmem[r]);
            end
        end
        n_tests++;
        if (dmem[15] !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL discarded_store: got %h expected ffffffff", dmem[15]);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_stale_read();
        test_load_store();
        test_branch();
        test_jal_x0();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
